// File: rtl/mlp_pkg.sv
// Shared state encoding and phase-timing helpers for the MLP layer sequencer.
package mlp_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    LOAD_WEIGHT  = 4'd1,
    LOAD_ACT     = 4'd2,
    COMPUTE      = 4'd3,
    DRAIN        = 4'd4,
    TRANSFER     = 4'd5,
    NEXT_LAYER   = 4'd6,
    WAIT_WEIGHTS = 4'd7,
    DONE         = 4'd8,
    ERROR        = 4'd9
  } state_t;

  localparam int unsigned STATE_W = 4;

  // Cycles needed to flush partial sums out of an array_n x array_n systolic array.
  function automatic int unsigned drain_cycles(input int unsigned array_n);
    return 2 * array_n + 3;
  endfunction

endpackage

// File: rtl/mlp_phase_counter.sv
// Saturating phase counter with synchronous clear, count enable and terminal-match flag.
module mlp_phase_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term);

endmodule

// File: rtl/mlp_sequencer.sv
// Layer-by-layer control sequencer for a systolic-array MLP engine: weight load,
// activation load, compute, drain, activation transfer and inter-layer handshakes.
module mlp_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned ARRAY_N      = 2,
  parameter int unsigned MAX_LAYERS   = 8,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned AP_LAT       = 4,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [$clog2(MAX_LAYERS+1)-1:0] num_layers,
  input  logic [CNT_W-1:0]                vec_len,
  input  logic                            weights_ready,
  input  logic                            act_ready,
  output logic [3:0]                      state,
  output logic [$clog2(MAX_LAYERS)-1:0]   layer,
  output logic                            buf_sel,
  output logic                            wf_pop,
  output logic [ARRAY_N-1:0]              capture_col,
  output logic                            ub_rd_ready,
  output logic                            mmu_valid,
  output logic                            refill_en,
  output logic                            busy,
  output logic                            done,
  output logic                            err_timeout,
  output logic                            err_cfg
);

  localparam int unsigned NLW    = $clog2(MAX_LAYERS + 1);
  localparam int unsigned LYW    = $clog2(MAX_LAYERS);
  // The phase counter must span both the longest COMPUTE phase
  // (vec_len + ARRAY_N - 1, which overflows CNT_W) and the full wait timeout.
  localparam int unsigned RUN_W  = CNT_W + 1;
  localparam int unsigned WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam int unsigned CW     = (RUN_W > WAIT_W) ? RUN_W : WAIT_W;

  state_t           state_q, state_d;
  logic [LYW-1:0]   layer_q, layer_d;
  logic             buf_sel_q, buf_sel_d;
  logic [NLW-1:0]   num_layers_q, num_layers_d;
  logic [CNT_W-1:0] vec_len_q, vec_len_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_cfg_q, err_cfg_d;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    term;
  logic             at_term;
  logic             cnt_clr;
  logic             busy_int;
  logic             kill;
  logic             cfg_bad;

  assign busy_int = !(state_q inside {IDLE, DONE, ERROR});
  assign kill     = abort && busy_int;
  assign cfg_bad  = (num_layers == '0) || (num_layers > NLW'(MAX_LAYERS)) || (vec_len == '0);
  assign cnt_clr  = (state_d != state_q);

  mlp_phase_counter #(
    .W (CW)
  ) u_phase_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .en      (busy_int),
    .term    (term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  // Last cnt value of each timed phase.
  always_comb begin
    term = '0;
    case (state_q)
      LOAD_WEIGHT:  term = CW'(ARRAY_N);
      COMPUTE:      term = CW'(vec_len_q) + CW'(ARRAY_N - 2);
      DRAIN:        term = CW'(drain_cycles(ARRAY_N) - 1);
      TRANSFER:     term = CW'(AP_LAT - 1);
      WAIT_WEIGHTS: term = CW'(WAIT_TIMEOUT - 1);
      default:      term = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      layer_q       <= '0;
      buf_sel_q     <= 1'b0;
      num_layers_q  <= '0;
      vec_len_q     <= '0;
      err_timeout_q <= 1'b0;
      err_cfg_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      buf_sel_q     <= buf_sel_d;
      num_layers_q  <= num_layers_d;
      vec_len_q     <= vec_len_d;
      err_timeout_q <= err_timeout_d;
      err_cfg_q     <= err_cfg_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    buf_sel_d     = buf_sel_q;
    num_layers_d  = num_layers_q;
    vec_len_d     = vec_len_q;
    err_timeout_d = err_timeout_q;
    err_cfg_d     = err_cfg_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          num_layers_d  = num_layers;
          vec_len_d     = vec_len;
          layer_d       = '0;
          buf_sel_d     = 1'b0;
          err_timeout_d = 1'b0;
          err_cfg_d     = cfg_bad;
          state_d       = cfg_bad ? ERROR : LOAD_WEIGHT;
        end
      end
      LOAD_WEIGHT: begin
        if (at_term) state_d = (layer_q == '0) ? LOAD_ACT : COMPUTE;
      end
      LOAD_ACT: begin
        if (act_ready) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (at_term) state_d = DRAIN;
      end
      DRAIN: begin
        if (at_term) begin
          state_d = ((NLW'(layer_q) + NLW'(1)) < num_layers_q) ? TRANSFER : DONE;
        end
      end
      TRANSFER: begin
        if (at_term) state_d = NEXT_LAYER;
      end
      NEXT_LAYER: begin
        state_d   = WAIT_WEIGHTS;
        buf_sel_d = ~buf_sel_q;
        layer_d   = layer_q + LYW'(1);
      end
      WAIT_WEIGHTS: begin
        if (weights_ready) begin
          state_d = LOAD_WEIGHT;
        end else if (at_term) begin
          state_d       = ERROR;
          err_timeout_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition and any bookkeeping it would have done.
    if (kill) begin
      state_d       = IDLE;
      layer_d       = layer_q;
      buf_sel_d     = buf_sel_q;
      err_timeout_d = err_timeout_q;
    end
  end

  always_comb begin
    state       = state_q;
    layer       = layer_q;
    buf_sel     = buf_sel_q;
    busy        = busy_int;
    done        = (state_q == DONE);
    err_timeout = err_timeout_q;
    err_cfg     = err_cfg_q;
    wf_pop      = 1'b0;
    capture_col = '0;
    ub_rd_ready = 1'b0;
    mmu_valid   = 1'b0;
    refill_en   = 1'b0;
    if (!kill) begin
      case (state_q)
        LOAD_WEIGHT: begin
          wf_pop = 1'b1;
          for (int unsigned k = 0; k < ARRAY_N; k++) begin
            capture_col[k] = (cnt == CW'(k + 1));
          end
        end
        COMPUTE: begin
          ub_rd_ready = (cnt < CW'(vec_len_q));
          mmu_valid   = (cnt >= CW'(ARRAY_N));
        end
        DRAIN: begin
          mmu_valid = 1'b1;
          refill_en = 1'b1;
        end
        TRANSFER: refill_en = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_sequencer.sv
// Self-checking bench for mlp_sequencer: ARRAY_N=2 and ARRAY_N=4 instances, per-cycle scoreboards.
module tb_mlp_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, start, start4, abort, wr, ar;
  logic [3:0] nl;
  logic [5:0] vl;

  logic [3:0] state, state4;
  logic [2:0] layer, layer4;
  logic       buf_sel, wf_pop, ub_rd_ready, mmu_valid, refill_en, busy, done, err_timeout, err_cfg;
  logic [1:0] capture_col;
  logic       buf4, wf4, ub4, mmu4, ref4, busy4, done4, errt4, errc4;
  logic [3:0] cap4;

  int total = 0;
  int bad   = 0;

  mlp_sequencer #(.ARRAY_N(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .num_layers(nl), .vec_len(vl), .weights_ready(wr), .act_ready(ar),
    .state(state), .layer(layer), .buf_sel(buf_sel), .wf_pop(wf_pop),
    .capture_col(capture_col), .ub_rd_ready(ub_rd_ready), .mmu_valid(mmu_valid),
    .refill_en(refill_en), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_cfg(err_cfg)
  );

  mlp_sequencer #(.ARRAY_N(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .abort(abort),
    .num_layers(nl), .vec_len(vl), .weights_ready(wr), .act_ready(ar),
    .state(state4), .layer(layer4), .buf_sel(buf4), .wf_pop(wf4),
    .capture_col(cap4), .ub_rd_ready(ub4), .mmu_valid(mmu4),
    .refill_en(ref4), .busy(busy4), .done(done4),
    .err_timeout(errt4), .err_cfg(errc4)
  );

  logic [17:0] all2;
  logic [19:0] all4;
  assign all2 = {state, layer, buf_sel, wf_pop, capture_col, ub_rd_ready, mmu_valid,
                 refill_en, busy, done, err_timeout, err_cfg};
  assign all4 = {state4, layer4, buf4, wf4, cap4, ub4, mmu4, ref4, busy4, done4, errt4, errc4};

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] lay;
    logic       bsel;
    logic       dn;
  } e2_t;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] cap;
    logic       wf;
    logic       ub;
    logic       mmu;
    logic       rf;
    logic       dn;
    logic       bsy;
  } e4_t;

  e2_t q2[$];
  e4_t q4[$];

  function automatic void push2(input logic [3:0] st, input int n, input logic [2:0] lay,
                                input logic bsel);
    e2_t e;
    for (int i = 0; i < n; i++) begin
      e.st = st; e.lay = lay; e.bsel = bsel; e.dn = (st == 4'd8);
      q2.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; start4 = 0; abort = 0; wr = 0; ar = 0; nl = '0; vl = '0;
    #1;
    total++;
    if (all2 !== 18'd0) begin bad++; $display("FAIL reset_outputs_n2 got=%h exp=0", all2); end
    total++;
    if (all4 !== 20'd0) begin bad++; $display("FAIL reset_outputs_n4 got=%h exp=0", all4); end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    total++;
    if ({state, busy} !== 5'd0) begin bad++; $display("FAIL reset_release_idle got=%h exp=0", {state, busy}); end
  endtask

  task automatic test_two_layer();
    e2_t e;
    int cyc = 0;
    int dn = 0;
    q2.delete();
    push2(4'd1, 3, 3'd0, 1'b0); push2(4'd2, 1, 3'd0, 1'b0); push2(4'd3, 3, 3'd0, 1'b0);
    push2(4'd4, 7, 3'd0, 1'b0); push2(4'd5, 4, 3'd0, 1'b0); push2(4'd6, 1, 3'd0, 1'b0);
    push2(4'd7, 1, 3'd1, 1'b1); push2(4'd1, 3, 3'd1, 1'b1); push2(4'd3, 3, 3'd1, 1'b1);
    push2(4'd4, 7, 3'd1, 1'b1); push2(4'd8, 1, 3'd1, 1'b1); push2(4'd0, 1, 3'd1, 1'b1);
    nl = 4'd2; vl = 6'd2; wr = 1; ar = 1; start = 1;
    while (q2.size() > 0 && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 2) nl = 4'd1;   // changing config while busy must not matter
      if (cyc == 5) start = 0;   // start held while busy is ignored
      e = q2.pop_front();
      dn += int'(done);
      total++;
      if ({state, layer, buf_sel, done} !== {e.st, e.lay, e.bsel, e.dn}) begin
        bad++;
        $display("FAIL trace2 cyc=%0d got st=%0d lay=%0d buf=%0d done=%0d exp st=%0d lay=%0d buf=%0d done=%0d",
                 cyc, state, layer, buf_sel, done, e.st, e.lay, e.bsel, e.dn);
      end
    end
    total++;
    if (dn !== 1) begin bad++; $display("FAIL done_count2 got=%0d exp=1", dn); end
  endtask

  task automatic test_capture_n4();
    e4_t e;
    logic [3:0] one = 4'b0001;
    int cyc = 0;
    q4.delete();
    for (int k = 0; k < 5; k++) begin
      e = '0; e.st = 4'd1; e.wf = 1; e.bsy = 1;
      e.cap = (k == 0) ? 4'b0000 : (one << (k - 1));
      q4.push_back(e);
    end
    e = '0; e.st = 4'd2; e.bsy = 1; q4.push_back(e);
    for (int c = 0; c < 8; c++) begin
      e = '0; e.st = 4'd3; e.bsy = 1; e.ub = (c < 5); e.mmu = (c >= 4);
      q4.push_back(e);
    end
    for (int c = 0; c < 11; c++) begin
      e = '0; e.st = 4'd4; e.bsy = 1; e.mmu = 1; e.rf = 1;
      q4.push_back(e);
    end
    e = '0; e.st = 4'd8; e.dn = 1; q4.push_back(e);
    e = '0; e.st = 4'd0; q4.push_back(e);
    nl = 4'd1; vl = 6'd5; wr = 1; ar = 1; start4 = 1;
    while (q4.size() > 0 && cyc < 100) begin
      tick();
      cyc++;
      if (cyc == 1) start4 = 0;
      e = q4.pop_front();
      total++;
      if ({state4, cap4, wf4, ub4, mmu4, ref4, done4, busy4} !== e) begin
        bad++;
        $display("FAIL trace4 cyc=%0d got st=%0d cap=%b wf=%b ub=%b mmu=%b rf=%b dn=%b bsy=%b exp %h",
                 cyc, state4, cap4, wf4, ub4, mmu4, ref4, done4, busy4, e);
      end
    end
    total++;
    if ({buf4, layer4, errt4, errc4} !== 6'd0) begin
      bad++; $display("FAIL single_layer_buf got=%b exp=0", {buf4, layer4, errt4, errc4});
    end
  endtask

  task automatic test_timeout();
    int wcnt = 0;
    int dn = 0;
    bit got_err = 0;
    nl = 4'd3; vl = 6'd2; wr = 0; ar = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      dn += int'(done);
      if (state == 4'd9) begin got_err = 1; break; end
      if (state == 4'd7) wcnt++;
    end
    total++;
    if (got_err !== 1'b1) begin bad++; $display("FAIL timeout_reached got=%0d exp=1", got_err); end
    total++;
    if (wcnt !== 255) begin bad++; $display("FAIL wait_cycles got=%0d exp=255", wcnt); end
    total++;
    if ({err_timeout, err_cfg, busy} !== 3'b100) begin
      bad++; $display("FAIL timeout_flags got=%b exp=100", {err_timeout, err_cfg, busy});
    end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL timeout_no_done got=%0d exp=0", dn); end
    tick();
    total++;
    if ({state, err_timeout} !== 5'b0000_1) begin
      bad++; $display("FAIL timeout_sticky got=%b exp=00001", {state, err_timeout});
    end
    wr = 1;
  endtask

  task automatic test_cfg_err();
    int wfs = 0;
    nl = 4'd0; vl = 6'd2; start = 1;
    tick(); wfs += int'(wf_pop);
    total++;
    if ({state, err_cfg, err_timeout, busy} !== {4'd9, 3'b100}) begin
      bad++; $display("FAIL cfg_layers0 got=%b exp=1001100", {state, err_cfg, err_timeout, busy});
    end
    tick(); wfs += int'(wf_pop);
    total++;
    if (state !== 4'd9) begin bad++; $display("FAIL error_hold got=%0d exp=9", state); end
    start = 0;
    tick(); wfs += int'(wf_pop);
    total++;
    if ({state, err_cfg} !== 5'b0000_1) begin bad++; $display("FAIL error_exit got=%b exp=00001", {state, err_cfg}); end
    nl = 4'd2; vl = 6'd0; start = 1;
    tick(); wfs += int'(wf_pop);
    total++;
    if ({state, err_cfg} !== 5'b1001_1) begin bad++; $display("FAIL cfg_vec0 got=%b exp=10011", {state, err_cfg}); end
    start = 0;
    tick(); wfs += int'(wf_pop);
    nl = 4'd9; vl = 6'd2; start = 1;
    tick(); wfs += int'(wf_pop);
    total++;
    if ({state, err_cfg} !== 5'b1001_1) begin bad++; $display("FAIL cfg_layers9 got=%b exp=10011", {state, err_cfg}); end
    start = 0;
    tick(); wfs += int'(wf_pop);
    nl = 4'd2; start = 1; abort = 1;
    tick(); wfs += int'(wf_pop);
    total++;
    if ({state, err_cfg} !== 5'b0000_1) begin
      bad++; $display("FAIL start_abort_idle got=%b exp=00001", {state, err_cfg});
    end
    start = 0; abort = 0;
    total++;
    if (wfs !== 0) begin bad++; $display("FAIL cfg_no_wf_pop got=%0d exp=0", wfs); end
  endtask

  task automatic test_abort();
    int dn = 0;
    bit fin = 0;
    nl = 4'd2; vl = 6'd2; wr = 1; ar = 1; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    total++;
    if ({state, ub_rd_ready} !== {4'd3, 1'b1}) begin
      bad++; $display("FAIL abort_position got=%b exp=00111", {state, ub_rd_ready});
    end
    abort = 1;
    #1;
    total++;
    if ({wf_pop, capture_col, ub_rd_ready, mmu_valid, refill_en} !== 6'd0) begin
      bad++; $display("FAIL abort_strobes got=%b exp=0", {wf_pop, capture_col, ub_rd_ready, mmu_valid, refill_en});
    end
    tick();
    total++;
    if ({state, busy, done} !== 6'd0) begin bad++; $display("FAIL abort_idle got=%b exp=0", {state, busy, done}); end
    abort = 0; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      dn += int'(done);
      if (state == 4'd0) begin fin = 1; break; end
    end
    total++;
    if ({fin, dn[3:0]} !== 5'b1_0001) begin bad++; $display("FAIL abort_rerun fin=%0d done=%0d exp fin=1 done=1", fin, dn); end
    total++;
    if ({layer, buf_sel} !== 4'b001_1) begin bad++; $display("FAIL rerun_layer got=%b exp=0011", {layer, buf_sel}); end
  endtask

  task automatic test_reset_mid_run();
    int dn = 0;
    bit seen = 0;
    bit fin = 0;
    nl = 4'd2; vl = 6'd2; wr = 1; ar = 1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      dn += int'(done);
      if (state == 4'd4) begin seen = 1; break; end
    end
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL reach_drain got=%0d exp=1", seen); end
    tick(); tick();
    dn += int'(done);
    reset_n = 0;
    #1;
    total++;
    if ({all2, all4} !== 38'd0) begin bad++; $display("FAIL async_reset got=%h_%h exp=0", all2, all4); end
    total++;
    if (dn !== 0) begin bad++; $display("FAIL reset_no_done got=%0d exp=0", dn); end
    #2;
    reset_n = 1; start = 1;
    tick();
    total++;
    if (state !== 4'd1) begin bad++; $display("FAIL start_after_reset got=%0d exp=1", state); end
    start = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      dn += int'(done);
      if (state == 4'd0) begin fin = 1; break; end
    end
    total++;
    if ({fin, dn[3:0]} !== 5'b1_0001) begin bad++; $display("FAIL reset_rerun fin=%0d done=%0d exp fin=1 done=1", fin, dn); end
  endtask

  initial begin
    test_reset();
    test_two_layer();
    test_capture_n4();
    test_timeout();
    test_cfg_err();
    test_abort();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlp_sequencer.md
MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 Params SHALL be: ARRAY_N, 2, systolic array dimension (2..8); MAX_LAYERS, 8, layer-count ceiling; CNT_W, 6, phase-counter width; AP_LAT, 4, activation-pipeline latency in cycles; WAIT_TIMEOUT, 255, WAIT_WEIGHTS cycle limit.
REQ-002 Ports SHALL be: clk in 1 clock; reset_n in 1 async active-low reset; start in 1 run request; abort in 1 cancel run; num_layers in $clog2(MAX_LAYERS+1) layers this run; vec_len in CNT_W activation vectors per layer; weights_ready in 1 next-layer weights present; act_ready in 1 initial activations loaded.
REQ-003 Ports (out) SHALL be: state 4 FSM state; layer $clog2(MAX_LAYERS) current layer; buf_sel 1 activation-read buffer (0=A); wf_pop 1 weight-FIFO pop; capture_col ARRAY_N one-hot column capture; ub_rd_ready 1 UB read; mmu_valid 1 accumulator valid_in; refill_en 1 UB write-back window; busy 1; done 1 one-cycle completion pulse; err_timeout 1 sticky; err_cfg 1 sticky.
REQ-004 Clock SHALL be one clock, clk; reset SHALL be asynchronous, active-low, named reset_n.

Function
REQ-005 States SHALL be IDLE=0, LOAD_WEIGHT=1, LOAD_ACT=2, COMPUTE=3, DRAIN=4, TRANSFER=5, NEXT_LAYER=6, WAIT_WEIGHTS=7, DONE=8, ERROR=9; cnt is a CNT_W counter cleared on every state change.
REQ-006 IDLE: on start, SHALL latch num_layers/vec_len, set layer=0, buf_sel=0, go LOAD_WEIGHT; if latched num_layers==0, >MAX_LAYERS, or vec_len==0, go ERROR and set err_cfg instead.
REQ-007 LOAD_WEIGHT SHALL last ARRAY_N+1 cycles (cnt 0..ARRAY_N), wf_pop=1 throughout, capture_col[k]=1 only at cnt==k+1; exit to LOAD_ACT if layer==0 else COMPUTE.
REQ-008 LOAD_ACT SHALL hold until act_ready=1, then go COMPUTE next cycle.
REQ-009 COMPUTE SHALL last vec_len+ARRAY_N-1 cycles; ub_rd_ready=1 only while cnt<vec_len; mmu_valid=1 while cnt>=ARRAY_N.
REQ-010 DRAIN SHALL last 2*ARRAY_N+3 cycles with mmu_valid=1 and refill_en=1; exit to TRANSFER if layer<num_layers-1, else DONE.
REQ-011 TRANSFER SHALL last AP_LAT cycles with refill_en=1, then NEXT_LAYER.
REQ-012 NEXT_LAYER SHALL last one cycle: toggle buf_sel, increment layer, go WAIT_WEIGHTS.
REQ-013 WAIT_WEIGHTS: on weights_ready=1 SHALL go LOAD_WEIGHT; if cnt reaches WAIT_TIMEOUT first, go ERROR and set err_timeout; cnt saturates, never wraps.
REQ-014 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-015 ERROR SHALL hold until start=0 then go IDLE; err_* flags clear only on next accepted start or reset.
REQ-016 busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-017 abort=1 in any busy state SHALL force IDLE next cycle, deassert all strobes that cycle, no done pulse; abort has priority over every transition.
REQ-018 start while busy SHALL be ignored; start and abort together in IDLE SHALL stay IDLE.
REQ-019 Strobe outputs (wf_pop, capture_col, ub_rd_ready, mmu_valid, refill_en) SHALL be combinational decodes of state/cnt; no output may glitch across state change beyond one decode.
REQ-020 num_layers==1 SHALL go DRAIN->DONE with no TRANSFER/NEXT_LAYER; buf_sel stays 0.

Reset
REQ-021 On reset_n=0 all outputs SHALL be 0, state IDLE, cnt 0, latched config 0, errors cleared, asynchronously; reset mid-run SHALL abandon the run without done.
REQ-022 Exit from reset SHALL take effect on the first clk edge after reset_n rises; start sampled that edge is valid.

Structure
REQ-023 The state enum, state encodings and a timing-constant function drain_cycles(ARRAY_N) SHALL live in shared package mlp_pkg.
REQ-024 One sub-module SHALL be used: mlp_phase_counter (CNT_W saturating counter with clear/enable/terminal-match).
REQ-025 No datapath (weights, activations, accumulators) SHALL be inside this block.

Verification
REQ-026 ARRAY_N=2, num_layers=2, vec_len=2, weights_ready and act_ready tied 1 -> state trace 0,1x3,2,3x3,4x7,5x4,6,7,1x3,3x3,4x7,8; done pulse once; buf_sel 0 then 1.
REQ-027 ARRAY_N=4, vec_len=5 -> capture_col 0001,0010,0100,1000 at LOAD_WEIGHT cnt 1..4; COMPUTE 8 cycles; mmu_valid high COMPUTE cnt 4..7 plus 11 DRAIN cycles.
REQ-028 num_layers=3, weights_ready held 0 after layer 0 -> ERROR after 255 WAIT_WEIGHTS cycles, err_timeout=1, busy=0, no done.
REQ-029 start with num_layers=0, then separately vec_len=0 -> ERROR, err_cfg=1, no wf_pop ever asserted.
REQ-030 abort asserted in COMPUTE cnt 1, and separately reset_n pulsed low in DRAIN -> IDLE next cycle / immediately, all strobes 0, no done, fresh start then completes normally.
